player_renderer: RTL and testbench

PLAYER_RENDERER -- requirements
Module: player_renderer

---
 rtl/player_renderer.sv | 209 ++++++++++++++++++++
 tb/tb_player_renderer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_renderer.sv
// -----------------------------------------------------------------------------
// player_renderer
// Draws the player sprite, a solid rectangle, onto the VGA pixel stream.
//
// The sprite position is copied from the player controller once per frame, on
// the frame tick. That copy is then held for the whole frame, so the sprite
// never tears. On a hit the sprite blinks in 8-frame phases for BLINK_FRAMES
// frames. The first phase is dark.
//
// Pipeline:
//   stage 1 (on pixel_en)        : compare the pixel against the sprite box
//   stage 2 (the following clock): choose the colour
//
// Ports:
//   CLOCK_50            system clock; all logic runs on its rising edge
//   reset_n             asynchronous active-low reset
//   pixel_en            one-cycle strobe marking a new pixel coordinate
//   pix_x, pix_y [9:0]  current VGA pixel coordinate
//   active              the pixel lies in the 640x480 visible area
//   player_x/y  [9:0]   live sprite top-left position
//   hit                 one-cycle pulse that starts or restarts a blink
//   red/green/blue[7:0] registered pixel colour
//   out_valid           one-cycle pulse; the colour outputs carry a new pixel
//   sprite_on           the current output pixel is a drawn sprite pixel
// -----------------------------------------------------------------------------
module player_renderer #(
    parameter int          PLAYER_W     = 32,
    parameter int          PLAYER_H     = 16,
    parameter logic [23:0] PLAYER_RGB   = 24'h00FF00,
    parameter logic [23:0] BG_RGB       = 24'h000000,
    parameter int          BLINK_FRAMES = 64
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       pixel_en,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       active,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       hit,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       out_valid,
    output logic       sprite_on
);

    localparam logic [9:0]  SX_MAX    = 10'(640 - PLAYER_W);
    localparam logic [9:0]  SY_MAX    = 10'(480 - PLAYER_H);
    localparam logic [9:0]  SX_RST    = 10'((640 - PLAYER_W) / 2);
    localparam logic [9:0]  SY_RST    = 10'(480 - 4 - PLAYER_H);
    localparam logic [10:0] W11       = 11'(PLAYER_W);
    localparam logic [10:0] H11       = 11'(PLAYER_H);
    localparam logic [6:0]  FCNT_LAST = 7'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BLINK_OFF = 2'd1,
        ST_BLINK_ON  = 2'd2
    } blink_state_t;

    logic         frame_tick_s;
    logic [9:0]   sx_r, sy_r;
    logic [9:0]   clamp_x_s, clamp_y_s;
    logic         inside_s;
    logic         visible_s;
    blink_state_t state_r, state_nxt_s;
    logic [6:0]   fcnt_r, fcnt_nxt_s;
    logic [2:0]   phase_r, phase_nxt_s;
    logic         s1_valid_r, s1_inside_r, s1_active_r, s1_visible_r;
    logic [23:0]  colour_s;

    // Frame tick, shadow-position clamp and sprite-box compare.
    // The compare uses 11-bit sums so that sx+W cannot wrap.
    always_comb begin
        frame_tick_s = pixel_en & (pix_x == 10'd0) & (pix_y == 10'd480);
        clamp_x_s    = (player_x > SX_MAX) ? SX_MAX : player_x;
        clamp_y_s    = (player_y > SY_MAX) ? SY_MAX : player_y;
        inside_s     = active
                     & ({1'b0, pix_x} >= {1'b0, sx_r})
                     & ({1'b0, pix_x} <  ({1'b0, sx_r} + W11))
                     & ({1'b0, pix_y} >= {1'b0, sy_r})
                     & ({1'b0, pix_y} <  ({1'b0, sy_r} + H11));
        visible_s    = (state_r != ST_BLINK_OFF);
    end

    // Shadow sprite position, reloaded only on the frame tick.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sx_r <= SX_RST;
            sy_r <= SY_RST;
        end else if (frame_tick_s) begin
            sx_r <= clamp_x_s;
            sy_r <= clamp_y_s;
        end
    end

    // Blink FSM next-state logic. A hit wins over a coincident frame tick.
    always_comb begin
        state_nxt_s = state_r;
        fcnt_nxt_s  = fcnt_r;
        phase_nxt_s = phase_r;
        case (state_r)
            ST_IDLE: begin
                if (hit) begin
                    state_nxt_s = ST_BLINK_OFF;
                    fcnt_nxt_s  = 7'd0;
                    phase_nxt_s = 3'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BLINK_OFF, ST_BLINK_ON: begin
                if (hit) begin
                    state_nxt_s = ST_BLINK_OFF;
                    fcnt_nxt_s  = 7'd0;
                    phase_nxt_s = 3'd0;
                end else if (frame_tick_s) begin
                    if (fcnt_r == FCNT_LAST) begin
                        state_nxt_s = ST_IDLE;
                        fcnt_nxt_s  = 7'd0;
                        phase_nxt_s = 3'd0;
                    end else begin
                        fcnt_nxt_s  = fcnt_r + 7'd1;
                        phase_nxt_s = phase_r + 3'd1;
                        // The phase wrapping from 7 to 0 flips the sprite on or off.
                        if (phase_r == 3'd7) begin
                            state_nxt_s = (state_r == ST_BLINK_OFF) ? ST_BLINK_ON : ST_BLINK_OFF;
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                fcnt_nxt_s  = 7'd0;
                phase_nxt_s = 3'd0;
            end
        endcase
    end

    // Blink FSM state and counter registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            fcnt_r  <= 7'd0;
            phase_r <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
            phase_r <= phase_nxt_s;
        end
    end

    // Stage 1: capture the compare result.
    // visible is captured here, so an FSM change only affects pixels whose
    // stage 1 comes after it.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r   <= 1'b0;
            s1_inside_r  <= 1'b0;
            s1_active_r  <= 1'b0;
            s1_visible_r <= 1'b1;
        end else begin
            s1_valid_r <= pixel_en;
            if (pixel_en) begin
                s1_inside_r  <= inside_s;
                s1_active_r  <= active;
                s1_visible_r <= visible_s;
            end
        end
    end

    // Colour select for stage 2.
    always_comb begin
        colour_s = 24'h000000;
        if (s1_inside_r && s1_visible_r) begin
            colour_s = PLAYER_RGB;
        end else if (s1_active_r) begin
            colour_s = BG_RGB;
        end else begin
            colour_s = 24'h000000;
        end
    end

    // Stage 2: register the outputs. The colour holds between valid pixels.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            red       <= 8'd0;
            green     <= 8'd0;
            blue      <= 8'd0;
            out_valid <= 1'b0;
            sprite_on <= 1'b0;
        end else begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                red       <= colour_s[23:16];
                green     <= colour_s[15:8];
                blue      <= colour_s[7:0];
                sprite_on <= s1_inside_r & s1_visible_r;
            end
        end
    end

endmodule

// File: tb/tb_player_renderer.sv
// -----------------------------------------------------------------------------
// tb_player_renderer
// Self-checking bench for player_renderer.
// The reference model keeps three values:
//   - the latched sprite box
//   - the clamp rule
//   - the number of frames since the last hit
// It derives visibility arithmetically from that frame count.
// -----------------------------------------------------------------------------
module tb_player_renderer;

    localparam int W = 32;
    localparam int H = 16;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic       pixel_en;
    logic [9:0] pix_x, pix_y;
    logic       active;
    logic [9:0] player_x, player_y;
    logic       hit;
    logic [7:0] red, green, blue;
    logic       out_valid;
    logic       sprite_on;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_sx;
    int m_sy;
    int m_age;   // frames since the last hit; -1 means no blink in progress

    player_renderer dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .pixel_en (pixel_en),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .active   (active),
        .player_x (player_x),
        .player_y (player_y),
        .hit      (hit),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .out_valid(out_valid),
        .sprite_on(sprite_on)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic bit m_visible();
        return (m_age < 0) || (((m_age / 8) % 2) == 1);
    endfunction

    function automatic bit m_inside(input int x, input int y, input bit act);
        return act && (x >= m_sx) && (x < m_sx + W) && (y >= m_sy) && (y < m_sy + H);
    endfunction

    task automatic model_reset();
        m_sx  = 304;
        m_sy  = 460;
        m_age = -1;
    endtask

    task automatic model_tick(input bit with_hit);
        m_sx = (int'(player_x) > 640 - W) ? 640 - W : int'(player_x);
        m_sy = (int'(player_y) > 480 - H) ? 480 - H : int'(player_y);
        if (with_hit) begin
            m_age = 0;
        end else if (m_age >= 0) begin
            m_age++;
            if (m_age >= 64) m_age = -1;
        end
    endtask

    // Sends one pixel and checks the result after exactly 2 clocks.
    // It also checks that out_valid drops again and the colour holds.
    task automatic send_pixel(input int x, input int y, input bit act, input bit h, input string tag);
        logic [23:0] exp_rgb;
        bit          exp_spr;
        bit          tick;
        @(negedge CLOCK_50);
        pix_x    = x[9:0];
        pix_y    = y[9:0];
        active   = act;
        hit      = h;
        pixel_en = 1'b1;
        exp_spr  = m_inside(x, y, act) && m_visible();
        exp_rgb  = exp_spr ? 24'h00FF00 : 24'h000000;
        tick     = (x == 0) && (y == 480);
        @(posedge CLOCK_50);
        if (tick) model_tick(h);
        else if (h) m_age = 0;
        @(negedge CLOCK_50);
        pixel_en = 1'b0;
        hit      = 1'b0;
        @(posedge CLOCK_50);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s valid (%0d,%0d): got %b exp 1", tag, x, y, out_valid);
        end
        n_checks++;
        if ({red, green, blue} !== exp_rgb) begin
            n_fail++;
            $display("FAIL %s rgb (%0d,%0d): got %h exp %h", tag, x, y, {red, green, blue}, exp_rgb);
        end
        n_checks++;
        if (sprite_on !== exp_spr) begin
            n_fail++;
            $display("FAIL %s sprite_on (%0d,%0d): got %b exp %b", tag, x, y, sprite_on, exp_spr);
        end
        @(posedge CLOCK_50);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || {red, green, blue} !== exp_rgb) begin
            n_fail++;
            $display("FAIL %s hold (%0d,%0d): got valid %b rgb %h exp 0 %h", tag, x, y, out_valid, {red, green, blue}, exp_rgb);
        end
    endtask

    task automatic do_tick(input bit h);
        send_pixel(0, 480, 1'b0, h, "tick");
    endtask

    task automatic set_player(input int x, input int y);
        @(negedge CLOCK_50);
        player_x = x[9:0];
        player_y = y[9:0];
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        pixel_en = 1'b0;
        pix_x    = 10'd0;
        pix_y    = 10'd0;
        active   = 1'b0;
        player_x = 10'd0;
        player_y = 10'd0;
        hit      = 1'b0;
        model_reset();
        repeat (3) @(posedge CLOCK_50);
        #1;
        n_checks++;
        if ({red, green, blue, out_valid, sprite_on} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rgb %h valid %b spr %b exp 0", {red, green, blue}, out_valid, sprite_on);
        end
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLOCK_50);
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle_valid: got %b exp 0", out_valid);
            end
        end
        send_pixel(304, 460, 1'b1, 1'b0, "reset_pos_tl");
        send_pixel(335, 475, 1'b1, 1'b0, "reset_pos_br");
        send_pixel(336, 475, 1'b1, 1'b0, "reset_pos_out");
    endtask

    task automatic test_basic();
        set_player(100, 200);
        do_tick(1'b0);
        send_pixel(100, 200, 1'b1, 1'b0, "basic_tl");
        send_pixel(132, 200, 1'b1, 1'b0, "basic_right_edge");
        send_pixel(131, 215, 1'b1, 1'b0, "basic_br");
        send_pixel(131, 216, 1'b1, 1'b0, "basic_below");
        send_pixel(99, 200, 1'b1, 1'b0, "basic_left");
    endtask

    task automatic test_no_tear();
        set_player(300, 200);
        send_pixel(100, 200, 1'b1, 1'b0, "tear_old_pos");
        send_pixel(300, 200, 1'b1, 1'b0, "tear_new_pos_early");
        do_tick(1'b0);
        send_pixel(300, 200, 1'b1, 1'b0, "tear_new_pos");
        send_pixel(100, 200, 1'b1, 1'b0, "tear_old_gone");
    endtask

    task automatic test_clamp();
        set_player(700, 479);
        do_tick(1'b0);
        send_pixel(639, 479, 1'b1, 1'b0, "clamp_br");
        send_pixel(608, 464, 1'b1, 1'b0, "clamp_tl");
        send_pixel(607, 464, 1'b1, 1'b0, "clamp_left");
        send_pixel(608, 463, 1'b1, 1'b0, "clamp_above");
    endtask

    task automatic test_inactive();
        set_player(100, 200);
        do_tick(1'b0);
        send_pixel(100, 200, 1'b0, 1'b0, "inactive_inside");
        send_pixel(110, 205, 1'b1, 1'b0, "inactive_ref");
    endtask

    task automatic test_blink();
        set_player(100, 200);
        do_tick(1'b0);
        send_pixel(5, 5, 1'b1, 1'b1, "blink_hit");
        for (int k = 1; k <= 68; k++) begin
            send_pixel(110, 205, 1'b1, 1'b0, "blink_frame");
            do_tick(1'b0);
        end
        send_pixel(110, 205, 1'b1, 1'b0, "blink_idle");
        // Restart part-way through: the hit lands on the 20th tick.
        send_pixel(5, 5, 1'b1, 1'b1, "blink_hit2");
        for (int k = 1; k <= 19; k++) begin
            do_tick(1'b0);
        end
        do_tick(1'b1);
        for (int k = 1; k <= 10; k++) begin
            send_pixel(110, 205, 1'b1, 1'b0, "blink_restart");
            do_tick(1'b0);
        end
        // Run the blink out to idle so later tests start with the sprite visible.
        for (int k = 0; k < 60; k++) do_tick(1'b0);
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_q[$];
        bit          spr_q[$];
        int          xs[6];
        xs = '{100, 131, 132, 99, 115, 120};
        set_player(100, 200);
        do_tick(1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50);
            if (i < 6) begin
                pix_x    = xs[i][9:0];
                pix_y    = 10'd207;
                active   = 1'b1;
                pixel_en = 1'b1;
                spr_q.push_back(m_inside(xs[i], 207, 1'b1) && m_visible());
                exp_q.push_back((m_inside(xs[i], 207, 1'b1) && m_visible()) ? 24'h00FF00 : 24'h000000);
            end else begin
                pixel_en = 1'b0;
            end
            @(posedge CLOCK_50);
            #1;
            if (i >= 1 && i <= 6) begin
                n_checks++;
                if (out_valid !== 1'b1 || {red, green, blue} !== exp_q[i-1] || sprite_on !== spr_q[i-1]) begin
                    n_fail++;
                    $display("FAIL b2b pixel %0d: got valid %b rgb %h spr %b exp 1 %h %b", i - 1, out_valid, {red, green, blue}, sprite_on, exp_q[i-1], spr_q[i-1]);
                end
            end else if (i == 7) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b end valid: got %b exp 0", out_valid);
                end
            end
        end
    endtask

    task automatic test_random();
        int x;
        int y;
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 9))
                0: begin
                    set_player($urandom_range(0, 1023), $urandom_range(0, 1023));
                    do_tick($urandom_range(0, 7) == 0);
                end
                1: begin
                    set_player($urandom_range(0, 1023), $urandom_range(0, 1023));
                end
                2: begin
                    send_pixel($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b1, "rand_hit");
                end
                default: begin
                    x = m_sx + $urandom_range(0, W + 8) - 4;
                    y = m_sy + $urandom_range(0, H + 8) - 4;
                    if (x < 0) x = 0;
                    if (x > 639) x = 639;
                    if (y < 0) y = 0;
                    if (y > 479) y = 479;
                    send_pixel(x, y, $urandom_range(0, 5) != 0, 1'b0, "rand_pixel");
                end
            endcase
        end
    endtask

    task automatic test_reset_inflight();
        set_player(500, 100);
        do_tick(1'b0);
        send_pixel(5, 5, 1'b1, 1'b1, "inflight_hit");
        @(negedge CLOCK_50);
        pix_x    = 10'd510;
        pix_y    = 10'd105;
        active   = 1'b1;
        pixel_en = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        pix_x = 10'd600;
        @(posedge CLOCK_50);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({red, green, blue, out_valid, sprite_on} !== 26'd0) begin
            n_fail++;
            $display("FAIL inflight_reset_outputs: got rgb %h valid %b spr %b exp 0", {red, green, blue}, out_valid, sprite_on);
        end
        @(negedge CLOCK_50);
        pixel_en = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLOCK_50);
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL inflight_no_valid: got %b exp 0", out_valid);
            end
        end
        send_pixel(304, 460, 1'b1, 1'b0, "inflight_pos_tl");
        send_pixel(335, 475, 1'b1, 1'b0, "inflight_pos_br");
        send_pixel(303, 460, 1'b1, 1'b0, "inflight_pos_left");
        send_pixel(304, 476, 1'b1, 1'b0, "inflight_pos_below");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_tear();
        test_clamp();
        test_inactive();
        test_blink();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
